xosera_bus_ctrl: RTL and testbench

XOSERA_BUS_CTRL -- requirements
Module: xosera_bus_ctrl

---
 rtl/xosera_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_xosera_bus_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xosera_bus_ctrl.sv
// Asynchronous 8-bit host bus to 16-bit register file bridge.
// Latency: write request 1 clk after synchronized start; read data on bus_data_o 3 clk after start.
// Backpressure: one pending write is held until reg_wr_ready_i; a further odd-byte write is dropped and flagged.
module xosera_bus_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        bus_cs_n_i,
    input  logic        bus_rd_nwr_i,
    input  logic        bus_bytesel_i,
    input  logic [3:0]  bus_reg_num_i,
    input  logic [7:0]  bus_data_i,
    output logic [7:0]  bus_data_o,
    output logic        reg_wr_valid_o,
    input  logic        reg_wr_ready_i,
    output logic [3:0]  reg_wr_num_o,
    output logic [15:0] reg_wr_data_o,
    output logic [3:0]  reg_rd_num_o,
    input  logic [15:0] reg_rd_data_i,
    output logic        reg_rd_done_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ACC   = 2'd1,
        RD_FETCH = 2'd2,
        RD_ACC   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] rw_sync;
    logic [SYNC_STAGES-1:0] fill_sh;
    logic                   cs_s;
    logic                   rw_s;
    logic                   cs_prev;
    logic                   armed;
    logic                   acc_start;
    logic                   acc_end;

    logic                   cap_bytesel;
    logic [3:0]             cap_reg_num;
    logic [7:0]             hi_hold;
    logic [15:0]            rd_buf;
    logic                   rd_first;

    logic                   rd_num_ld;
    logic                   buf_ld;
    logic                   done_nxt;
    logic                   wr_start;
    logic                   wr_odd;
    logic                   wr_accept;

    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign rw_s = rw_sync[SYNC_STAGES-1];

    // fill_sh marks when the chain holds pin samples rather than reset values, so a
    // cs_n held low across reset release must first be seen high before a start counts.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cs_sync <= '1;
            rw_sync <= '0;
            fill_sh <= '0;
            cs_prev <= 1'b1;
            armed   <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], bus_cs_n_i};
            rw_sync <= {rw_sync[SYNC_STAGES-2:0], bus_rd_nwr_i};
            fill_sh <= {fill_sh[SYNC_STAGES-2:0], 1'b1};
            cs_prev <= cs_s;
            armed   <= armed | (fill_sh[SYNC_STAGES-1] & cs_s);
        end
    end

    assign acc_start = armed & cs_prev & ~cs_s;
    assign acc_end   = ~cs_prev & cs_s;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_num_ld = 1'b0;
        buf_ld    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (acc_start) begin
                    state_nxt = rw_s ? RD_FETCH : WR_ACC;
                end
            end
            WR_ACC: begin
                if (acc_end) begin
                    state_nxt = IDLE;
                end
            end
            RD_FETCH: begin
                rd_num_ld = 1'b1;
                state_nxt = acc_end ? IDLE : RD_ACC;
            end
            RD_ACC: begin
                buf_ld = rd_first;
                if (acc_end) begin
                    state_nxt = IDLE;
                    done_nxt  = cap_bytesel;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields are stable for the whole access, so the start cycle uses them directly.
    assign wr_start  = (state == IDLE) && acc_start && !rw_s;
    assign wr_odd    = wr_start && bus_bytesel_i;
    assign wr_accept = !reg_wr_valid_o || reg_wr_ready_i;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cap_bytesel <= 1'b0;
            cap_reg_num <= '0;
        end else if ((state == IDLE) && acc_start) begin
            cap_bytesel <= bus_bytesel_i;
            cap_reg_num <= bus_reg_num_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hi_hold        <= '0;
            reg_wr_valid_o <= 1'b0;
            reg_wr_num_o   <= '0;
            reg_wr_data_o  <= '0;
            overrun_o      <= 1'b0;
        end else begin
            if (wr_start && !bus_bytesel_i) begin
                hi_hold <= bus_data_i;
            end
            if (wr_odd && wr_accept) begin
                reg_wr_valid_o <= 1'b1;
                reg_wr_num_o   <= bus_reg_num_i;
                reg_wr_data_o  <= {hi_hold, bus_data_i};
            end else if (reg_wr_ready_i) begin
                reg_wr_valid_o <= 1'b0;
            end
            if (wr_odd && !wr_accept) begin
                overrun_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            reg_rd_num_o  <= '0;
            rd_buf        <= '0;
            rd_first      <= 1'b0;
            bus_data_o    <= '0;
            reg_rd_done_o <= 1'b0;
        end else begin
            if (rd_num_ld) begin
                reg_rd_num_o <= cap_reg_num;
            end
            if (buf_ld) begin
                rd_buf <= reg_rd_data_i;
            end
            rd_first      <= (state == RD_FETCH) && !acc_end;
            bus_data_o    <= cap_bytesel ? rd_buf[7:0] : rd_buf[15:8];
            reg_rd_done_o <= done_nxt;
        end
    end

endmodule

// File: tb/tb_xosera_bus_ctrl.sv
// Directed bench for xosera_bus_ctrl: writes, reads, short access, reset mid-access, back-to-back writes.
module tb_xosera_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        bus_cs_n_i;
    logic        bus_rd_nwr_i;
    logic        bus_bytesel_i;
    logic [3:0]  bus_reg_num_i;
    logic [7:0]  bus_data_i;
    logic [7:0]  bus_data_o;
    logic        reg_wr_valid_o;
    logic        reg_wr_ready_i;
    logic [3:0]  reg_wr_num_o;
    logic [15:0] reg_wr_data_o;
    logic [3:0]  reg_rd_num_o;
    logic [15:0] reg_rd_data_i;
    logic        reg_rd_done_o;
    logic        overrun_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xosera_bus_ctrl #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .bus_cs_n_i     (bus_cs_n_i),
        .bus_rd_nwr_i   (bus_rd_nwr_i),
        .bus_bytesel_i  (bus_bytesel_i),
        .bus_reg_num_i  (bus_reg_num_i),
        .bus_data_i     (bus_data_i),
        .bus_data_o     (bus_data_o),
        .reg_wr_valid_o (reg_wr_valid_o),
        .reg_wr_ready_i (reg_wr_ready_i),
        .reg_wr_num_o   (reg_wr_num_o),
        .reg_wr_data_o  (reg_wr_data_o),
        .reg_rd_num_o   (reg_rd_num_o),
        .reg_rd_data_i  (reg_rd_data_i),
        .reg_rd_done_o  (reg_rd_done_o),
        .overrun_o      (overrun_o)
    );

    // Register file read model: reg 9 holds 0xBEEF, others {C,n,3,n}.
    always_comb begin
        reg_rd_data_i = {4'hC, reg_rd_num_o, 4'h3, reg_rd_num_o};
        if (reg_rd_num_o == 4'd9) begin
            reg_rd_data_i = 16'hBEEF;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drops cs_n and returns 1 ns after the edge on which the start takes effect.
    task automatic acc_begin(input logic rd, input logic bs, input logic [3:0] num, input logic [7:0] dat);
        bus_rd_nwr_i  = rd;
        bus_bytesel_i = bs;
        bus_reg_num_i = num;
        bus_data_i    = dat;
        bus_cs_n_i    = 1'b0;
        cyc(3);
    endtask

    // Raises cs_n and returns 1 ns after the edge on which the end takes effect.
    task automatic acc_finish();
        bus_cs_n_i = 1'b1;
        cyc(3);
    endtask

    initial begin
        logic [7:0] d;
        reset_n_i      = 1'b0;
        bus_cs_n_i     = 1'b1;
        bus_rd_nwr_i   = 1'b0;
        bus_bytesel_i  = 1'b0;
        bus_reg_num_i  = 4'd0;
        bus_data_i     = 8'd0;
        reg_wr_ready_i = 1'b0;
        cyc(2);
        chk("rst_wr_valid", 16'(reg_wr_valid_o), 16'h0);
        chk("rst_rd_done",  16'(reg_rd_done_o),  16'h0);
        chk("rst_overrun",  16'(overrun_o),      16'h0);
        chk("rst_bus_data", 16'(bus_data_o),     16'h0);
        chk("rst_rd_num",   16'(reg_rd_num_o),   16'h0);
        chk("rst_wr_num",   16'(reg_wr_num_o),   16'h0);
        chk("rst_wr_data",  reg_wr_data_o,       16'h0);
        reset_n_i = 1'b1;
        cyc(4);

        // Odd write with ready low: request holds, then a second odd write overruns.
        acc_begin(1'b0, 1'b1, 4'd2, 8'h56);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 16'(reg_wr_valid_o), 16'h1);
            chk("hold_num",   16'(reg_wr_num_o),   16'h2);
            chk("hold_data",  reg_wr_data_o,       16'h0056);
            cyc(1);
        end
        acc_finish();
        cyc(1);
        acc_begin(1'b0, 1'b1, 4'd3, 8'h77);
        chk("ovr_flag",  16'(overrun_o),      16'h1);
        chk("ovr_valid", 16'(reg_wr_valid_o), 16'h1);
        chk("ovr_num",   16'(reg_wr_num_o),   16'h2);
        chk("ovr_data",  reg_wr_data_o,       16'h0056);
        acc_finish();
        reg_wr_ready_i = 1'b1;
        cyc(1);
        chk("ovr_drain_valid", 16'(reg_wr_valid_o), 16'h0);

        // Even 0x12 then odd 0x34 to reg 5 with ready held high.
        cyc(2);
        acc_begin(1'b0, 1'b0, 4'd5, 8'h12);
        chk("even_no_valid", 16'(reg_wr_valid_o), 16'h0);
        acc_finish();
        cyc(1);
        acc_begin(1'b0, 1'b1, 4'd5, 8'h34);
        chk("pair_valid", 16'(reg_wr_valid_o), 16'h1);
        chk("pair_num",   16'(reg_wr_num_o),   16'h5);
        chk("pair_data",  reg_wr_data_o,       16'h1234);
        cyc(1);
        chk("pair_single_cycle", 16'(reg_wr_valid_o), 16'h0);
        acc_finish();
        chk("ovr_sticky", 16'(overrun_o), 16'h1);

        // Reads of reg 9: even then odd byte.
        cyc(2);
        acc_begin(1'b1, 1'b0, 4'd9, 8'h00);
        cyc(1);
        chk("rd_num", 16'(reg_rd_num_o), 16'h9);
        cyc(1);
        chk("rd_latency_early", 16'(bus_data_o), 16'h00);
        cyc(1);
        chk("rd_even_byte", 16'(bus_data_o), 16'hBE);
        chk("rd_even_no_done_mid", 16'(reg_rd_done_o), 16'h0);
        acc_finish();
        chk("rd_even_no_done_end", 16'(reg_rd_done_o), 16'h0);
        cyc(2);
        acc_begin(1'b1, 1'b1, 4'd9, 8'h00);
        cyc(3);
        chk("rd_odd_byte", 16'(bus_data_o), 16'hEF);
        chk("rd_odd_no_done_mid", 16'(reg_rd_done_o), 16'h0);
        acc_finish();
        chk("rd_odd_done", 16'(reg_rd_done_o), 16'h1);
        cyc(1);
        chk("rd_odd_done_pulse", 16'(reg_rd_done_o), 16'h0);

        // Short odd read of reg 4, ending while the fetch is still in progress.
        cyc(2);
        bus_rd_nwr_i  = 1'b1;
        bus_bytesel_i = 1'b1;
        bus_reg_num_i = 4'd4;
        bus_cs_n_i    = 1'b0;
        cyc(1);
        bus_cs_n_i    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("short_no_done", 16'(reg_rd_done_o), 16'h0);
            chk("short_buf_kept", 16'(bus_data_o), 16'hEF);
        end
        cyc(2);
        acc_begin(1'b1, 1'b0, 4'd4, 8'h00);
        cyc(3);
        chk("after_short_read", 16'(bus_data_o), 16'hC4);
        acc_finish();
        chk("after_short_no_done", 16'(reg_rd_done_o), 16'h0);

        // Reset while a write is pending and cs_n is still low.
        reg_wr_ready_i = 1'b0;
        cyc(1);
        acc_begin(1'b0, 1'b1, 4'd1, 8'h99);
        chk("pre_rst_valid", 16'(reg_wr_valid_o), 16'h1);
        chk("pre_rst_data",  reg_wr_data_o,       16'h1299);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_valid",    16'(reg_wr_valid_o), 16'h0);
        chk("mid_rst_overrun",  16'(overrun_o),      16'h0);
        chk("mid_rst_bus_data", 16'(bus_data_o),     16'h00);
        cyc(1);
        reset_n_i = 1'b1;
        cyc(8);
        chk("no_start_cs_low", 16'(reg_wr_valid_o), 16'h0);
        bus_cs_n_i = 1'b1;
        cyc(4);
        acc_begin(1'b0, 1'b1, 4'd1, 8'hAB);
        chk("post_rst_valid", 16'(reg_wr_valid_o), 16'h1);
        chk("post_rst_data",  reg_wr_data_o,       16'h00AB);
        acc_finish();
        reg_wr_ready_i = 1'b1;
        cyc(1);
        chk("post_rst_drain", 16'(reg_wr_valid_o), 16'h0);

        // Back-to-back odd writes with 4-clk cs_n gaps and ready always high.
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            d = 8'h40 + 8'(i * 17);
            acc_begin(1'b0, 1'b1, 4'(6 + i), d);
            chk("b2b_valid", 16'(reg_wr_valid_o), 16'h1);
            chk("b2b_num",   16'(reg_wr_num_o),   16'(6 + i));
            chk("b2b_data",  reg_wr_data_o,       {8'h00, d});
            cyc(1);
            chk("b2b_clear", 16'(reg_wr_valid_o), 16'h0);
            bus_cs_n_i = 1'b1;
            cyc(4);
        end
        chk("b2b_no_overrun", 16'(overrun_o), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
